// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter.
// master: requesters (req/we/addr/wdata out; ack/rdata/busy in).
// slave: the arbiter.
interface regfile_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addra0;
  logic [ADDR_W-1:0] addra1;
  logic [ADDR_W-1:0] addrb0;
  logic [ADDR_W-1:0] addrb1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              busy;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output req0, req1, we0, we1,
    output addra0, addra1, addrb0, addrb1,
    output wdata0, wdata1,
    input  ack0, ack1, busy, rdata1, rdata2
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addra0, addra1, addrb0, addrb1,
    input  wdata0, wdata1,
    output ack0, ack1, busy, rdata1, rdata2
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter serialising reads/writes onto the 8x8
// register file's single ctrl/address/data port.
// Ports: clk, reset (async, active-high); bus = requester
// handshake (slave modport); rf_* = register-file port.
// REGFILE_ARB_RR_EN: round-robin arbitration when defined,
// fixed priority (requester 0 wins) otherwise.
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  regfile_arbiter_if.slave  bus,
  output logic              rf_ctrl,
  output logic [DATA_W-1:0] rf_in,
  output logic [ADDR_W-1:0] rf_inaddr,
  output logic [ADDR_W-1:0] rf_out1addr,
  output logic [ADDR_W-1:0] rf_out2addr,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LATCH,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic              any_req;
  logic              grant;
  logic              win;
  logic              gnt;
  logic              wr;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_a;
  logic [ADDR_W-1:0] sel_b;
  logic [DATA_W-1:0] sel_d;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic              ack0_c;
  logic              ack1_c;
  logic              busy_c;
  logic              ctrl_c;

  assign any_req = bus.req0 | bus.req1;
  assign grant   = (state == IDLE) && any_req;

`ifdef REGFILE_ARB_RR_EN
  // prio names the requester that wins a tie next.
  logic prio;

  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1)
      win = prio;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio <= 1'b0;
    else if (grant)
      prio <= ~win;
  end
`else
  always_comb win = ~bus.req0;
`endif

  always_comb begin
    sel_we = bus.we0;
    sel_a  = bus.addra0;
    sel_b  = bus.addrb0;
    sel_d  = bus.wdata0;
    if (win) begin
      sel_we = bus.we1;
      sel_a  = bus.addra1;
      sel_b  = bus.addrb1;
      sel_d  = bus.wdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Outputs decode from state alone, so an async reset
  // drops ctrl back to read and kills any ack at once.
  always_comb begin
    state_nx = state;
    ack0_c   = 1'b0;
    ack1_c   = 1'b0;
    busy_c   = 1'b1;
    ctrl_c   = 1'b1;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (any_req)
          state_nx = ISSUE;
      end
      ISSUE: begin
        ctrl_c   = ~wr;
        state_nx = wr ? RESP : LATCH;
      end
      LATCH: begin
        state_nx = RESP;
      end
      RESP: begin
        ack0_c   = ~gnt;
        ack1_c   = gnt;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // rf_* registers double as the holding registers; they keep
  // their last value outside ISSUE, which is harmless as ctrl
  // reads then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt         <= 1'b0;
      wr          <= 1'b0;
      rf_in       <= '0;
      rf_inaddr   <= '0;
      rf_out1addr <= '0;
      rf_out2addr <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
    end else begin
      if (grant) begin
        gnt <= win;
        wr  <= sel_we;
        if (sel_we) begin
          rf_in     <= sel_d;
          rf_inaddr <= sel_a;
        end else begin
          rf_out1addr <= sel_a;
          rf_out2addr <= sel_b;
        end
      end
      if (state == LATCH) begin
        rd1_q <= rf_out1;
        rd2_q <= rf_out2;
      end
    end
  end

  assign rf_ctrl    = ctrl_c;
  assign bus.ack0   = ack0_c;
  assign bus.ack1   = ack1_c;
  assign bus.busy   = busy_c;
  assign bus.rdata1 = rd1_q;
  assign bus.rdata2 = rd2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed table,
// hand sequences (reset abort, arbitration) and random traffic.
module tb_regfile_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          rf_ctrl;
  logic [DW-1:0] rf_in;
  logic [DW-1:0] rf_out1;
  logic [DW-1:0] rf_out2;
  logic [AW-1:0] rf_inaddr;
  logic [AW-1:0] rf_out1addr;
  logic [AW-1:0] rf_out2addr;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .rf_ctrl     (rf_ctrl),
    .rf_in       (rf_in),
    .rf_inaddr   (rf_inaddr),
    .rf_out1addr (rf_out1addr),
    .rf_out2addr (rf_out2addr),
    .rf_out1     (rf_out1),
    .rf_out2     (rf_out2)
  );

  // Register file: write on falling edge, registered read.
  logic [DW-1:0] rf [8] = '{default: '0};
  always @(negedge clk)
    if (!rf_ctrl) rf[rf_inaddr] <= rf_in;
  always @(posedge clk)
    if (rf_ctrl) begin
      rf_out1 <= rf[rf_out1addr];
      rf_out2 <= rf[rf_out2addr];
    end

  // Requester drive
  logic [1:0]    rq  = '0;
  logic [1:0]    rwe = '0;
  logic [AW-1:0] ra [2] = '{default: '0};
  logic [AW-1:0] rb [2] = '{default: '0};
  logic [DW-1:0] rd [2] = '{default: '0};

  assign bus.req0   = rq[0];
  assign bus.req1   = rq[1];
  assign bus.we0    = rwe[0];
  assign bus.we1    = rwe[1];
  assign bus.addra0 = ra[0];
  assign bus.addra1 = ra[1];
  assign bus.addrb0 = rb[0];
  assign bus.addrb1 = rb[1];
  assign bus.wdata0 = rd[0];
  assign bus.wdata1 = rd[1];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  // Transaction-level reference: a grant happens at the first
  // edge where the arbiter is free and someone asks; a write
  // acks 2 edges later, a read 3; the next grant may come 3
  // (write) or 4 (read) edges after the previous one.
  int unsigned   edge_n    = 0;
  int unsigned   next_free = 0;
  int unsigned   g_edge    = 0;
  int unsigned   a_edge    = 0;
  logic          pend      = 1'b0;
  logic          last_g    = 1'b1;
  logic          m_w;
  logic          p_idx;
  logic          p_we;
  logic [AW-1:0] p_a;
  logic [AW-1:0] p_b;
  logic [DW-1:0] p_d;
  logic [DW-1:0] mm [8] = '{default: '0};
  logic [DW-1:0] e1 = '0;
  logic [DW-1:0] e2 = '0;
  logic          x_ack;

  initial forever begin
    @(posedge clk);
    edge_n++;
    if (reset) begin
      pend      = 1'b0;
      last_g    = 1'b1;
      next_free = 0;
    end else if (edge_n >= next_free && rq != 2'b00) begin
`ifdef REGFILE_ARB_RR_EN
      if (rq == 2'b11) m_w = ~last_g;
      else             m_w = rq[1];
`else
      m_w = rq[0] ? 1'b0 : 1'b1;
`endif
      last_g    = m_w;
      pend      = 1'b1;
      p_idx     = m_w;
      p_we      = rwe[m_w];
      p_a       = ra[m_w];
      p_b       = rb[m_w];
      p_d       = rd[m_w];
      g_edge    = edge_n;
      a_edge    = edge_n + (p_we ? 1 : 2);
      next_free = edge_n + (p_we ? 3 : 4);
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      pend = 1'b0;
      e1   = '0;
      e2   = '0;
      chk("rst_ack0",   bus.ack0,    0);
      chk("rst_ack1",   bus.ack1,    0);
      chk("rst_busy",   bus.busy,    0);
      chk("rst_ctrl",   rf_ctrl,     1);
      chk("rst_in",     rf_in,       0);
      chk("rst_inaddr", rf_inaddr,   0);
      chk("rst_o1addr", rf_out1addr, 0);
      chk("rst_o2addr", rf_out2addr, 0);
      chk("rst_rdata1", bus.rdata1,  0);
      chk("rst_rdata2", bus.rdata2,  0);
    end else begin
      x_ack = pend && (edge_n == a_edge);
      chk("ack0", bus.ack0, x_ack && !p_idx);
      chk("ack1", bus.ack1, x_ack && p_idx);
      chk("busy", bus.busy, pend);
      chk("rf_ctrl", rf_ctrl,
          !(pend && p_we && edge_n == g_edge));
      if (pend && edge_n == g_edge) begin
        if (p_we) begin
          chk("rf_inaddr", rf_inaddr, p_a);
          chk("rf_in",     rf_in,     p_d);
        end else begin
          chk("rf_out1addr", rf_out1addr, p_a);
          chk("rf_out2addr", rf_out2addr, p_b);
        end
      end
      if (x_ack) begin
        if (p_we) begin
          mm[p_a] = p_d;
        end else begin
          e1 = mm[p_a];
          e2 = mm[p_b];
        end
        pend = 1'b0;
      end
      chk("rdata1", bus.rdata1, e1);
      chk("rdata2", bus.rdata2, e2);
    end
  end

  task automatic request(input  int            i,
                         input  logic          w,
                         input  logic [AW-1:0] a,
                         input  logic [AW-1:0] b,
                         input  logic [DW-1:0] d,
                         output int unsigned   t0,
                         output int unsigned   ta,
                         output logic [DW-1:0] r1,
                         output logic [DW-1:0] r2);
    @(posedge clk);
    #1;
    rwe[i] = w;
    ra[i]  = a;
    rb[i]  = b;
    rd[i]  = d;
    rq[i]  = 1'b1;
    t0 = edge_n;
    ta = 0;
    r1 = '0;
    r2 = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((i == 0 && bus.ack0) ||
          (i == 1 && bus.ack1)) begin
        ta = edge_n;
        r1 = bus.rdata1;
        r2 = bus.rdata2;
        break;
      end
    end
    rq[i] = 1'b0;
    chk($sformatf("req%0d_acked", i), ta != 0, 1);
  endtask

  typedef struct {
    logic [1:0]    en;
    logic          we0;
    logic [AW-1:0] a0;
    logic [AW-1:0] b0;
    logic [DW-1:0] d0;
    logic          we1;
    logic [AW-1:0] a1;
    logic [AW-1:0] b1;
    logic [DW-1:0] d1;
    logic          first;
    logic [DW-1:0] x01;
    logic [DW-1:0] x02;
    logic [DW-1:0] x11;
    logic [DW-1:0] x12;
  } vec_t;

  vec_t          tbl [8];
  logic          rr_first;
  int unsigned   s0, t0, s1, t1;
  logic [DW-1:0] q01, q02, q11, q12;
  int unsigned   u0, v0, u1, v1;
  logic [DW-1:0] w01, w02, w11, w12;
  int            gq [$];

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
`ifdef REGFILE_ARB_RR_EN
    rr_first = 1'b1;
`else
    rr_first = 1'b0;
`endif
    tbl[0] = '{2'b01, 1'b1, 3'd3, 3'd0, 8'hA5,
               1'b0, 3'd0, 3'd0, 8'h00,
               1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{2'b10, 1'b0, 3'd0, 3'd0, 8'h00,
               1'b0, 3'd3, 3'd0, 8'h00,
               1'b0, 8'h00, 8'h00, 8'hA5, 8'h00};
    tbl[2] = '{2'b01, 1'b1, 3'd6, 3'd0, 8'h66,
               1'b0, 3'd0, 3'd0, 8'h00,
               1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{2'b11, 1'b1, 3'd1, 3'd0, 8'h11,
               1'b1, 3'd2, 3'd0, 8'h22,
               rr_first, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{2'b11, 1'b0, 3'd1, 3'd2, 8'h00,
               1'b0, 3'd6, 3'd3, 8'h00,
               rr_first, 8'h11, 8'h22, 8'h66, 8'hA5};
    tbl[5] = '{2'b01, 1'b1, 3'd7, 3'd0, 8'h3C,
               1'b0, 3'd0, 3'd0, 8'h00,
               1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{2'b10, 1'b0, 3'd0, 3'd0, 8'h00,
               1'b0, 3'd7, 3'd7, 8'h00,
               1'b0, 8'h00, 8'h00, 8'h3C, 8'h3C};
    tbl[7] = '{2'b11, 1'b1, 3'd0, 3'd0, 8'h5A,
               1'b0, 3'd0, 3'd1, 8'h00,
               1'b0, 8'h00, 8'h00, 8'h5A, 8'h11};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      s0 = 0; t0 = 0; s1 = 0; t1 = 0;
      fork
        if (tbl[k].en[0])
          request(0, tbl[k].we0, tbl[k].a0, tbl[k].b0,
                  tbl[k].d0, s0, t0, q01, q02);
        if (tbl[k].en[1])
          request(1, tbl[k].we1, tbl[k].a1, tbl[k].b1,
                  tbl[k].d1, s1, t1, q11, q12);
      join
      if (tbl[k].en == 2'b01)
        chk($sformatf("t%0d_lat0", k), t0 - s0,
            tbl[k].we0 ? 2 : 3);
      if (tbl[k].en == 2'b10)
        chk($sformatf("t%0d_lat1", k), t1 - s1,
            tbl[k].we1 ? 2 : 3);
      if (tbl[k].en == 2'b11)
        chk($sformatf("t%0d_first", k), t1 < t0,
            tbl[k].first);
      if (tbl[k].en[0] && !tbl[k].we0) begin
        chk($sformatf("t%0d_r0d1", k), q01, tbl[k].x01);
        chk($sformatf("t%0d_r0d2", k), q02, tbl[k].x02);
      end
      if (tbl[k].en[1] && !tbl[k].we1) begin
        chk($sformatf("t%0d_r1d1", k), q11, tbl[k].x11);
        chk($sformatf("t%0d_r1d2", k), q12, tbl[k].x12);
      end
    end

    // Reset during ISSUE of a write, before the falling edge.
    @(posedge clk);
    #1;
    rwe[0] = 1'b1;
    ra[0]  = 3'd5;
    rd[0]  = 8'hFF;
    rq[0]  = 1'b1;
    @(posedge clk);
    #1;
    rq[0] = 1'b0;
    chk("abort_issue_ctrl", rf_ctrl, 0);
    #1 reset = 1'b1;
    #1;
    chk("abort_ctrl", rf_ctrl,  1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack0", bus.ack0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_r5",     rf[5],      0);
    chk("abort_rdata1", bus.rdata1, 0);
    chk("abort_rdata2", bus.rdata2, 0);

    // Both requesters hold back-to-back reads.
    @(posedge clk);
    #1;
    rwe   = 2'b00;
    ra[0] = 3'd1;
    rb[0] = 3'd2;
    ra[1] = 3'd6;
    rb[1] = 3'd3;
    rq    = 2'b11;
    gq.delete();
    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      if (bus.ack0) gq.push_back(0);
      if (bus.ack1) gq.push_back(1);
    end
    rq = 2'b00;
    chk("hold_grants", gq.size(), 4);
    foreach (gq[k])
      chk($sformatf("hold_g%0d", k), gq[k],
          rr_first ? (k % 2) : 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("hold_drain", bus.busy, 0);

    // Random traffic from both requesters.
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          request(0, 1'($urandom), AW'($urandom),
                  AW'($urandom), DW'($urandom),
                  u0, v0, w01, w02);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          request(1, 1'($urandom), AW'($urandom),
                  AW'($urandom), DW'($urandom),
                  u1, v1, w11, w12);
        end
      end
    join

    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("end_idle", bus.busy, 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester access controller for the 8x8 register file: accepts read or write transactions from requester 0 and requester 1 via a REQ/ACK handshake. It serialises them onto the file's single shared CTRL/address/data port and returns read data. It sits between the register file and its two masters (instruction datapath and loader/debug port), and is the only block that drives the file's CTRL, IN and address inputs.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 3, register address width
- CLK  in  1  clock; all state on rising edge
- RESET  in  1  reset, asynchronous, active-high
- REQ0, REQ1  in  1  transaction request; held high until matching ACK
- WE0, WE1  in  1  1 = write, 0 = read
- ADDRA0, ADDRA1  in  ADDR_W  write address (write) or OUT1 address (read)
- ADDRB0, ADDRB1  in  ADDR_W  OUT2 address (read only; ignored on write)
- WDATA0, WDATA1  in  DATA_W  write data
- ACK0, ACK1  out  1  one-cycle completion pulse to the granted requester
- RDATA1, RDATA2  out  DATA_W  read results, valid while ACKn high, held until next read capture
- BUSY  out  1  high in every state except IDLE
- RF_CTRL  out  1  register-file CTRL: 0 = write, 1 = read
- RF_IN  out  DATA_W  register-file write data
- RF_INADDR, RF_OUT1ADDR, RF_OUT2ADDR  out  ADDR_W  register-file addresses
- RF_OUT1, RF_OUT2  in  DATA_W  register-file read outputs

## Operation
- FSM states: IDLE, ISSUE, LATCH, RESP.
- IDLE: if any REQ high at rising edge, pick winner, latch its WE/ADDRA/ADDRB/WDATA into holding registers, record grant index, go ISSUE; else stay.
- ISSUE: drive latched fields to RF_* ports; RF_CTRL = 0 for write, 1 for read.
  - Write: file stores on falling edge inside ISSUE; next state RESP.
  - Read: file samples on rising edge ending ISSUE; next state LATCH.
- LATCH (read only): RF_CTRL = 1; RF_OUT1/RF_OUT2 captured into RDATA1/RDATA2 at edge ending LATCH; next state RESP.
- RESP: ACK of granted requester high for exactly this cycle; next state IDLE unconditionally.
- RF_CTRL is 1 in every state except ISSUE-of-write. No spurious write can occur.
- RF_* address/data outputs hold last driven values outside ISSUE; RF_CTRL = 1 makes them harmless.
- ADDRB ignored for writes; RDATA unchanged by writes.
- REQ dropping before ACK: transaction still completes with latched fields (protocol violation, not an error).
- REQ of the losing requester stays pending; it is re-arbitrated in the next IDLE.

## Timing
- Reset values: state IDLE, ACK0 = ACK1 = 0, BUSY = 0, RDATA1 = RDATA2 = 0, RF_CTRL = 1, RF_IN = 0, all RF addresses 0, RR pointer = requester 0.
- RESET assertion acts immediately. RF_CTRL is forced to 1 and ACKs to 0 without waiting for CLK, so a write in ISSUE before its falling edge is aborted.
- REQ sampled at edge N in IDLE:
  - Write: ISSUE in cycle N+1, ACK high in cycle N+2.
  - Read: ISSUE in N+1, LATCH in N+2, ACK plus valid RDATA in cycle N+3.
- Requester must deassert REQ by the edge ending its ACK cycle, or it is granted again.
- Minimum spacing of grants: 3 cycles (write) or 4 cycles (read), including the IDLE cycle.

## Configuration
- REGFILE_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous REQ0 and REQ1 in IDLE, the requester not granted last wins.
  - The pointer updates on every grant.
- REGFILE_ARB_RR_EN undefined: fixed priority, requester 0 always wins. The pointer logic is absent.

## Test plan
- REQ0 write WE0=1 ADDRA0=3 WDATA0=0xA5, then REQ1 read ADDRA1=3 ADDRB1=0 -> ACK0 two cycles after sampling. ACK1 three cycles after its sampling, with RDATA1=0xA5 and RDATA2=reg0 contents.
- REQ0 and REQ1 asserted in same cycle, both held, writes to r1=0x11 and r2=0x22:
  - Without macro: ACK0 first.
  - With macro after prior grant to 0: ACK1 first.
  - Both complete; no lost request.
- Four back-to-back simultaneous reads with REGFILE_ARB_RR_EN -> grants alternate 0,1,0,1; without macro, REQ0 held continuously starves REQ1.
- RESET pulsed during ISSUE of write r5=0xFF before the falling edge -> ACK never pulses, RF_CTRL=1 immediately, r5 unchanged, BUSY=0, RDATA=0.
- Read with ADDRA=ADDRB=7 after writing r7=0x3C -> RDATA1=RDATA2=0x3C. RF_CTRL never 0 during any read transaction.
